// File: rtl/ctrl_exec_pkg.sv
// ctrl_exec_pkg: shared opcodes, flag bit positions and parameter defaults for the control execution pipe
package ctrl_exec_pkg;
    localparam int DATA_W_DEF      = 32;
    localparam int PC_W_DEF        = 32;
    localparam int IMM_W_DEF       = 16;
    localparam int TARGET_W_DEF    = 26;
    localparam int TAG_W_DEF       = 6;
    localparam int CNT_W_DEF       = 16;
    localparam int SIZE_OPCODE_I   = 4;
    localparam int EXECUTION_FLAGS = 8;
    localparam int FLAG_EXEC = 7;
    localparam int FLAG_COND = 5;
    localparam int FLAG_LINK = 4;
    localparam int FLAG_CTRL = 2;
    localparam int FLAG_MISP = 0;
    typedef enum logic [SIZE_OPCODE_I-1:0] {
        OP_JUMP = 4'd0, OP_JAL, OP_JR, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ,
        OP_BC1F, OP_BC1T
    } opcode_e;
    function automatic logic is_cond_branch(input logic [SIZE_OPCODE_I-1:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ};
    endfunction
endpackage

// File: rtl/ctrl_branch_resolve.sv
// ctrl_branch_resolve: combinational resolution of jumps and branches into next PC, link value and flags
module ctrl_branch_resolve
    import ctrl_exec_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PC_W     = PC_W_DEF,
    parameter int IMM_W    = IMM_W_DEF,
    parameter int TARGET_W = TARGET_W_DEF
) (
    input  logic [SIZE_OPCODE_I-1:0]   opcode_i,
    input  logic [DATA_W-1:0]          data1_i,
    input  logic [DATA_W-1:0]          data2_i,
    input  logic [IMM_W-1:0]           immd_i,
    input  logic [PC_W-1:0]            pc_i,
    input  logic [PC_W-1:0]            predicted_target_i,
    input  logic                       predicted_dir_i,
    output logic [PC_W-1:0]            result_o,
    output logic [PC_W-1:0]            next_pc_o,
    output logic                       direction_o,
    output logic [EXECUTION_FLAGS-1:0] flags_o
);
    logic [PC_W-1:0] pc8, taken_pc, jump_pc, d1_pc;
    logic eq, neg, zero, cond, link, exec, ctrl, misp, reg_jump, abs_jump;
    always_comb begin
        pc8         = pc_i + PC_W'(8);
        taken_pc    = pc8 + ({{(PC_W-IMM_W){immd_i[IMM_W-1]}}, immd_i} << 2);
        // absolute jumps keep the PC region bits and take the word target from the predictor field
        jump_pc     = {pc_i[PC_W-1:TARGET_W+2], predicted_target_i[TARGET_W-1:0], 2'b00};
        d1_pc       = PC_W'(data1_i);
        eq          = data1_i == data2_i;
        neg         = data1_i[DATA_W-1];
        zero        = data1_i == '0;
        cond        = is_cond_branch(opcode_i);
        direction_o = opcode_i == OP_BEQ  ? eq :
                      opcode_i == OP_BNE  ? !eq :
                      opcode_i == OP_BLEZ ? (neg || zero) :
                      opcode_i == OP_BGTZ ? (!neg && !zero) :
                      opcode_i == OP_BLTZ ? neg :
                      opcode_i == OP_BGEZ ? !neg : 1'b0;
        reg_jump    = opcode_i inside {OP_JR, OP_JALR};
        abs_jump    = opcode_i inside {OP_JUMP, OP_JAL};
        link        = opcode_i inside {OP_JAL, OP_JALR};
        exec        = reg_jump || abs_jump || cond;
        ctrl        = exec || opcode_i inside {OP_BC1F, OP_BC1T};
        misp        = reg_jump ? d1_pc != predicted_target_i : cond && direction_o != predicted_dir_i;
        next_pc_o   = reg_jump ? d1_pc : abs_jump ? jump_pc : direction_o ? taken_pc : pc8;
        result_o    = link ? pc8 : '0;
        flags_o            = '0;
        flags_o[FLAG_EXEC] = exec;
        flags_o[FLAG_COND] = cond;
        flags_o[FLAG_LINK] = link;
        flags_o[FLAG_CTRL] = ctrl;
        flags_o[FLAG_MISP] = misp;
    end
endmodule

// File: rtl/ctrl_exec_pipe.sv
// ctrl_exec_pipe: two-stage elastic control-transfer execution pipe with flush and saturating statistics
module ctrl_exec_pipe
    import ctrl_exec_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PC_W     = PC_W_DEF,
    parameter int IMM_W    = IMM_W_DEF,
    parameter int TARGET_W = TARGET_W_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [SIZE_OPCODE_I-1:0]   opcode_i,
    input  logic [DATA_W-1:0]          data1_i,
    input  logic [DATA_W-1:0]          data2_i,
    input  logic [IMM_W-1:0]           immd_i,
    input  logic [PC_W-1:0]            pc_i,
    input  logic [PC_W-1:0]            predictedTarget_i,
    input  logic                       predictedDir_i,
    input  logic [TAG_W-1:0]           tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PC_W-1:0]            result_o,
    output logic [PC_W-1:0]            nextPC_o,
    output logic                       direction_o,
    output logic [EXECUTION_FLAGS-1:0] flags_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic [CNT_W-1:0]           mispredCount_o,
    output logic [CNT_W-1:0]           ctrlCount_o
);
    logic                       s1_valid_q, s1_valid_d, s1_pd_q, s1_pd_d;
    logic [SIZE_OPCODE_I-1:0]   s1_op_q, s1_op_d;
    logic [DATA_W-1:0]          s1_d1_q, s1_d1_d, s1_d2_q, s1_d2_d;
    logic [IMM_W-1:0]           s1_imm_q, s1_imm_d;
    logic [PC_W-1:0]            s1_pc_q, s1_pc_d, s1_pt_q, s1_pt_d;
    logic [TAG_W-1:0]           s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic                       s2_valid_q, s2_valid_d, s2_dir_q, s2_dir_d;
    logic [PC_W-1:0]            s2_result_q, s2_result_d, s2_npc_q, s2_npc_d;
    logic [EXECUTION_FLAGS-1:0] s2_flags_q, s2_flags_d;
    logic [CNT_W-1:0]           misp_cnt_q, misp_cnt_d, ctrl_cnt_q, ctrl_cnt_d;
    logic [PC_W-1:0]            res_result, res_npc;
    logic                       res_dir, out_hs, s2_adv, accept;
    logic [EXECUTION_FLAGS-1:0] res_flags;

    ctrl_branch_resolve #(
        .DATA_W(DATA_W), .PC_W(PC_W), .IMM_W(IMM_W), .TARGET_W(TARGET_W)
    ) u_resolve (
        .opcode_i(s1_op_q), .data1_i(s1_d1_q), .data2_i(s1_d2_q), .immd_i(s1_imm_q),
        .pc_i(s1_pc_q), .predicted_target_i(s1_pt_q), .predicted_dir_i(s1_pd_q),
        .result_o(res_result), .next_pc_o(res_npc), .direction_o(res_dir), .flags_o(res_flags)
    );

    always_comb begin
        out_hs      = s2_valid_q && out_ready_i;
        s2_adv      = s1_valid_q && (!s2_valid_q || out_hs);
        in_ready_o  = !s1_valid_q || s2_adv;
        accept      = in_valid_i && in_ready_o;
        // flush wins over every advance, including an op accepted in the same cycle
        s1_valid_d  = !flush_i && (accept || (s1_valid_q && !s2_adv));
        s2_valid_d  = !flush_i && (s2_adv || (s2_valid_q && !out_hs));
        s1_op_d     = accept ? opcode_i : s1_op_q;
        s1_d1_d     = accept ? data1_i : s1_d1_q;
        s1_d2_d     = accept ? data2_i : s1_d2_q;
        s1_imm_d    = accept ? immd_i : s1_imm_q;
        s1_pc_d     = accept ? pc_i : s1_pc_q;
        s1_pt_d     = accept ? predictedTarget_i : s1_pt_q;
        s1_pd_d     = accept ? predictedDir_i : s1_pd_q;
        s1_tag_d    = accept ? tag_i : s1_tag_q;
        s2_result_d = s2_adv ? res_result : s2_result_q;
        s2_npc_d    = s2_adv ? res_npc : s2_npc_q;
        s2_dir_d    = s2_adv ? res_dir : s2_dir_q;
        s2_flags_d  = s2_adv ? res_flags : s2_flags_q;
        s2_tag_d    = s2_adv ? s1_tag_q : s2_tag_q;
        ctrl_cnt_d  = out_hs && s2_flags_q[FLAG_EXEC] && ctrl_cnt_q != '1 ? ctrl_cnt_q + CNT_W'(1) : ctrl_cnt_q;
        misp_cnt_d  = out_hs && s2_flags_q[FLAG_MISP] && misp_cnt_q != '1 ? misp_cnt_q + CNT_W'(1) : misp_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_d1_q     <= '0;
            s1_d2_q     <= '0;
            s1_imm_q    <= '0;
            s1_pc_q     <= '0;
            s1_pt_q     <= '0;
            s1_pd_q     <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_npc_q    <= '0;
            s2_dir_q    <= 1'b0;
            s2_flags_q  <= '0;
            s2_tag_q    <= '0;
            ctrl_cnt_q  <= '0;
            misp_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_d1_q     <= s1_d1_d;
            s1_d2_q     <= s1_d2_d;
            s1_imm_q    <= s1_imm_d;
            s1_pc_q     <= s1_pc_d;
            s1_pt_q     <= s1_pt_d;
            s1_pd_q     <= s1_pd_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_npc_q    <= s2_npc_d;
            s2_dir_q    <= s2_dir_d;
            s2_flags_q  <= s2_flags_d;
            s2_tag_q    <= s2_tag_d;
            ctrl_cnt_q  <= ctrl_cnt_d;
            misp_cnt_q  <= misp_cnt_d;
        end
    end

    assign out_valid_o    = s2_valid_q;
    assign result_o       = s2_result_q;
    assign nextPC_o       = s2_npc_q;
    assign direction_o    = s2_dir_q;
    assign flags_o        = s2_flags_q;
    assign tag_o          = s2_tag_q;
    assign ctrlCount_o    = ctrl_cnt_q;
    assign mispredCount_o = misp_cnt_q;
endmodule

// File: tb/tb_ctrl_exec_pipe.sv
// tb_ctrl_exec_pipe: randomized and directed scoreboard bench for ctrl_exec_pipe
module tb_ctrl_exec_pipe;
    import ctrl_exec_pkg::*;

    logic clk = 1'b0, reset_n = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [3:0]  opcode_i = '0;
    logic [31:0] data1_i = '0, data2_i = '0, pc_i = '0, predictedTarget_i = '0;
    logic [15:0] immd_i = '0;
    logic        predictedDir_i = 1'b0;
    logic [5:0]  tag_i = '0;
    logic        in_ready_o, out_valid_o, direction_o;
    logic [31:0] result_o, nextPC_o;
    logic [7:0]  flags_o;
    logic [5:0]  tag_o;
    logic [15:0] mispredCount_o, ctrlCount_o;
    logic        in_ready2, out_valid2, dir2;
    logic [31:0] result2, npc2;
    logic [7:0]  flags2;
    logic [5:0]  tag2;
    logic [1:0]  mis2, ctl2;

    ctrl_exec_pipe dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opcode_i(opcode_i), .data1_i(data1_i), .data2_i(data2_i), .immd_i(immd_i), .pc_i(pc_i),
        .predictedTarget_i(predictedTarget_i), .predictedDir_i(predictedDir_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o), .nextPC_o(nextPC_o),
        .direction_o(direction_o), .flags_o(flags_o), .tag_o(tag_o),
        .mispredCount_o(mispredCount_o), .ctrlCount_o(ctrlCount_o)
    );

    ctrl_exec_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready2),
        .opcode_i(opcode_i), .data1_i(data1_i), .data2_i(data2_i), .immd_i(immd_i), .pc_i(pc_i),
        .predictedTarget_i(predictedTarget_i), .predictedDir_i(predictedDir_i), .tag_i(tag_i),
        .out_valid_o(out_valid2), .out_ready_i(out_ready_i), .result_o(result2), .nextPC_o(npc2),
        .direction_o(dir2), .flags_o(flags2), .tag_o(tag2),
        .mispredCount_o(mis2), .ctrlCount_o(ctl2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [31:0] npc;
        logic        dir;
        logic [7:0]  flags;
        logic [5:0]  tag;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int checks = 0, errors = 0, cyc = 0, ctl = 0, mis = 0, accepts = 0;
    bit last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: behaviour written straight from the opcode rules with signed arithmetic
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                                   input logic [15:0] imm, input logic [31:0] pc, input logic [31:0] pt,
                                   input logic pd, input logic [5:0] tag, input bit lat);
        exp_t e;
        int off;
        logic [31:0] pc8, tgt;
        bit taken, cond, ex, lk, ct, mp;
        off = int'($signed(imm)) * 4;
        pc8 = pc + 32'd8;
        tgt = pc8 + 32'(off);
        e.npc = pc8; e.dir = 1'b0; taken = 0; cond = 0; ex = 1; lk = 0; ct = 1; mp = 0;
        case (op)
            OP_JUMP: e.npc = (pc & 32'hF000_0000) | ((pt & 32'h03FF_FFFF) << 2);
            OP_JAL:  begin e.npc = (pc & 32'hF000_0000) | ((pt & 32'h03FF_FFFF) << 2); lk = 1; end
            OP_JR:   begin e.npc = d1; mp = d1 != pt; end
            OP_JALR: begin e.npc = d1; mp = d1 != pt; lk = 1; end
            OP_BEQ:  begin cond = 1; taken = d1 == d2; end
            OP_BNE:  begin cond = 1; taken = d1 != d2; end
            OP_BLEZ: begin cond = 1; taken = $signed(d1) <= 0; end
            OP_BGTZ: begin cond = 1; taken = $signed(d1) > 0; end
            OP_BLTZ: begin cond = 1; taken = $signed(d1) < 0; end
            OP_BGEZ: begin cond = 1; taken = $signed(d1) >= 0; end
            OP_BC1F, OP_BC1T: ex = 0;
            default: begin ex = 0; ct = 0; end
        endcase
        if (cond) begin
            e.dir = taken;
            e.npc = taken ? tgt : pc8;
            mp = taken != pd;
        end
        e.result = lk ? pc8 : 32'd0;
        e.flags = (ex ? 8'h80 : 8'h00) | (cond ? 8'h20 : 8'h00) | (lk ? 8'h10 : 8'h00) |
                  (ct ? 8'h04 : 8'h00) | (mp ? 8'h01 : 8'h00);
        e.tag = tag;
        e.acc_cyc = 0;
        e.lat = lat;
        return e;
    endfunction

    task automatic set_in(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [15:0] imm, input logic [31:0] pc, input logic [31:0] pt,
                          input logic pd, input logic [5:0] tag, input bit lat);
        opcode_i = op; data1_i = d1; data2_i = d2; immd_i = imm; pc_i = pc;
        predictedTarget_i = pt; predictedDir_i = pd; tag_i = tag; in_valid_i = 1'b1;
        cur = model(op, d1, d2, imm, pc, pt, pd, tag, lat);
    endtask

    task automatic rand_in();
        logic [31:0] d1, d2, pt;
        case ($urandom_range(0, 3))
            0: d1 = 32'd0;
            1: d1 = 32'h8000_0000 | $urandom;
            default: d1 = $urandom;
        endcase
        d2 = $urandom_range(0, 1) ? d1 : $urandom;
        pt = $urandom_range(0, 1) ? d1 : $urandom;
        set_in(4'($urandom_range(0, 15)), d1, d2, 16'($urandom), $urandom, pt, 1'($urandom_range(0, 1)),
               6'($urandom), 0);
        in_valid_i = $urandom_range(0, 4) != 0;
    endtask

    // One cycle: record acceptance/flush just after the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        #1;
        last_acc = 0;
        if (reset_n) begin
            if (flush_i) q.delete();
            else if (in_valid_i && in_ready_o) begin
                cur.acc_cyc = cyc;
                q.push_back(cur);
                last_acc = 1;
                accepts++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(q.size()), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        q.delete();
        ctl = 0;
        mis = 0;
        #1;
        chk("mid_rst_valid", {out_valid_o, out_valid2}, 0);
        chk("mid_rst_cnt", {ctrlCount_o, mispredCount_o, ctl2, mis2}, 0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready_o, 1);
        @(posedge clk);
        #1;
    endtask

    logic        held = 0, h_dir;
    logic [31:0] h_res, h_npc;
    logic [7:0]  h_flags;
    logic [5:0]  h_tag;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) held = 0;
            else begin
                chk("ctrl_count", ctrlCount_o, ctl > 65535 ? 65535 : ctl);
                chk("mispred_count", mispredCount_o, mis > 65535 ? 65535 : mis);
                chk("ctrl_count_w2", ctl2, ctl > 3 ? 3 : ctl);
                chk("mispred_count_w2", mis2, mis > 3 ? 3 : mis);
                if (held) begin
                    chk("hold_valid", out_valid_o, 1);
                    chk("hold_pcs", {result_o, nextPC_o}, {h_res, h_npc});
                    chk("hold_misc", {direction_o, flags_o, tag_o}, {h_dir, h_flags, h_tag});
                end
                held = out_valid_o && !out_ready_i && !flush_i;
                {h_res, h_npc, h_dir, h_flags, h_tag} = {result_o, nextPC_o, direction_o, flags_o, tag_o};
                if (out_valid_o && out_ready_i) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got tag %0h expected no output (t=%0t)", tag_o, $time);
                    end else begin
                        e = q.pop_front();
                        chk("tag", tag_o, e.tag);
                        chk("result", result_o, e.result);
                        chk("next_pc", nextPC_o, e.npc);
                        chk("direction", direction_o, e.dir);
                        chk("flags", flags_o, e.flags);
                        if (e.lat) chk("latency", 64'(cyc - e.acc_cyc), 2);
                        if (e.flags[7]) ctl++;
                        if (e.flags[0]) mis++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [15:0] sv_c, sv_m;
        int n;
        #12;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_pcs", {result_o, nextPC_o}, 0);
        chk("rst_misc", {direction_o, flags_o, tag_o}, 0);
        chk("rst_counts", {ctrlCount_o, mispredCount_o}, 0);
        #1 reset_n = 1'b1;
        #1 chk("rst_in_ready", in_ready_o, 1);
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;

        set_in(OP_BEQ, 32'd5, 32'd5, 16'h0004, 32'h100, 32'h0, 1'b0, 6'd1, 1);
        tick(); in_valid_i = 1'b0; tick();
        chk("beq_valid", out_valid_o, 1);
        chk("beq_dir", direction_o, 1);
        chk("beq_npc", nextPC_o, 32'h118);
        chk("beq_flags", flags_o, 8'hA5);
        tick();
        chk("beq_mispred_count", mispredCount_o, 1);

        set_in(OP_BGEZ, 32'h8000_0000, 32'd0, 16'hFFFF, 32'h300, 32'h0, 1'b0, 6'd2, 1);
        tick(); in_valid_i = 1'b0; tick();
        chk("bgez_dir", direction_o, 0);
        chk("bgez_npc", nextPC_o, 32'h308);
        chk("bgez_flags", flags_o, 8'hA4);
        tick();

        set_in(OP_JALR, 32'h400, 32'd0, 16'h0, 32'h200, 32'h400, 1'b0, 6'd3, 1);
        tick(); in_valid_i = 1'b0; tick();
        chk("jalr_result", result_o, 32'h208);
        chk("jalr_npc", nextPC_o, 32'h400);
        chk("jalr_flags", flags_o, 8'h94);
        tick();

        set_in(OP_JUMP, 32'd0, 32'd0, 16'h0, 32'hA000_0040, 32'h0123_4567, 1'b1, 6'd4, 1); tick();
        set_in(OP_BC1T, 32'd1, 32'd1, 16'h8, 32'h40, 32'h0, 1'b1, 6'd5, 1); tick();
        set_in(4'd14, 32'd7, 32'd7, 16'h8, 32'h80, 32'h0, 1'b1, 6'd6, 1); tick();
        drain();

        out_ready_i = 1'b0;
        accepts = 0;
        for (int k = 0; k < 4; k++) begin
            rand_in();
            set_in(opcode_i, data1_i, data2_i, immd_i, pc_i, predictedTarget_i, predictedDir_i, 6'(6'h10 + k), 0);
            n = 0;
            do begin
                tick();
                n++;
                if (k == 2 && n == 1) out_ready_i = 1'b1;
            end while (!last_acc && n < 20);
            if (k == 1) begin
                chk("stall_in_ready", in_ready_o, 0);
                chk("stall_accepts", 64'(accepts), 2);
            end
        end
        drain();

        out_ready_i = 1'b0;
        set_in(OP_JR, 32'h10, 32'd0, 16'h0, 32'h20, 32'h99, 1'b0, 6'd7, 0); tick();
        set_in(OP_BNE, 32'h1, 32'h2, 16'h4, 32'h30, 32'h0, 1'b0, 6'd8, 0); tick();
        sv_c = ctrlCount_o;
        sv_m = mispredCount_o;
        set_in(OP_BEQ, 32'h1, 32'h2, 16'h4, 32'h50, 32'h0, 1'b1, 6'd9, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_valid", out_valid_o, 0);
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("flush_empty", out_valid_o, 0);
        end
        chk("flush_counts", {ctrlCount_o, mispredCount_o}, {sv_c, sv_m});

        for (int k = 0; k < 600; k++) begin
            rand_in();
            out_ready_i = $urandom_range(0, 3) != 0;
            flush_i = $urandom_range(0, 39) == 0;
            tick();
        end
        flush_i = 1'b0;
        drain();

        for (int k = 0; k < 6; k++) begin
            rand_in();
            tick();
        end
        in_valid_i = 1'b0;
        pulse_reset();
        for (int k = 0; k < 3; k++) tick();
        for (int k = 0; k < 5; k++) begin
            set_in(OP_BEQ, 32'd1, 32'd2, 16'h10, 32'h1000 + 32'(k * 4), 32'h0, 1'b1, 6'(6'h20 + k), 0);
            tick();
        end
        drain();
        tick();
        chk("sat_mispred_w2", mis2, 3);
        chk("sat_ctrl_w2", ctl2, 3);
        chk("nosat_mispred", mispredCount_o, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
